// File: rtl/mac_operand_tx.sv
// mac_operand_tx: AXI4-Stream master that streams {weight[i], data[i]}
// beats from two host-loaded register banks into the MAC datapath.
// Optional feature: define MAC_OPERAND_TLAST_EN to add m_axis_tlast.
module mac_operand_tx #(
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              wr_en,
    input  logic              wr_sel,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [7:0]        wr_data,
    input  logic [ADDR_W:0]   len,
    input  logic              start,
    output logic              busy,
    output logic              done,
    output logic              m_axis_tvalid,
    input  logic              m_axis_tready,
    output logic [15:0]       m_axis_tdata
`ifdef MAC_OPERAND_TLAST_EN
    ,
    output logic              m_axis_tlast
`endif
);

    localparam int DEPTH = 2 ** ADDR_W;
    localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W + 1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [7:0]      data_bank [DEPTH];
    logic [7:0]      wgt_bank  [DEPTH];
    logic [ADDR_W:0] idx_q;
    logic [ADDR_W:0] eff_len_q;
    logic [ADDR_W:0] len_eff;
    logic [ADDR_W:0] nxt_idx;
    logic [15:0]     tdata_q;
    logic            hs;
    logic            last_beat;

    // Status and valid come straight from the state register, so tready
    // never reaches an output combinationally.
    assign m_axis_tvalid = (state_q == STREAM);
    assign busy          = (state_q == STREAM);
    assign done          = (state_q == DONE);
    assign m_axis_tdata  = tdata_q;

    assign len_eff   = (len > DEPTH_L) ? DEPTH_L : len;
    assign hs        = m_axis_tvalid & m_axis_tready;
    assign nxt_idx   = idx_q + 1'b1;
    assign last_beat = (nxt_idx == eff_len_q);

    // State register
    always_ff @(posedge clk) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = (len_eff == '0) ? DONE : STREAM;
            STREAM:  if (hs && last_beat) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Beat index, latched length and output beat register; beat 0 is read
    // with the bank contents of the start cycle (a same-cycle write lands later).
    always_ff @(posedge clk) begin
        if (!reset) begin
            idx_q     <= '0;
            eff_len_q <= '0;
            tdata_q   <= '0;
        end else begin
            case (state_q)
                IDLE: if (start) begin
                    eff_len_q <= len_eff;
                    idx_q     <= '0;
                    if (len_eff != '0) tdata_q <= {wgt_bank[0], data_bank[0]};
                end
                STREAM: if (hs && !last_beat) begin
                    idx_q   <= nxt_idx;
                    tdata_q <= {wgt_bank[nxt_idx[ADDR_W-1:0]],
                                data_bank[nxt_idx[ADDR_W-1:0]]};
                end
                default: ;
            endcase
        end
    end

    // Host bank writes; locked out while a stream is reading the banks
    always_ff @(posedge clk) begin
        if (!reset) begin
            for (int i = 0; i < DEPTH; i++) begin
                data_bank[i] <= '0;
                wgt_bank[i]  <= '0;
            end
        end else if (wr_en && (state_q != STREAM)) begin
            if (wr_sel) wgt_bank[wr_addr]  <= wr_data;
            else        data_bank[wr_addr] <= wr_data;
        end
    end

`ifdef MAC_OPERAND_TLAST_EN
    logic tlast_q;
    assign m_axis_tlast = tlast_q;

    // tlast travels with the beat it marks, so it holds under backpressure
    always_ff @(posedge clk) begin
        if (!reset) begin
            tlast_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE: if (start && len_eff != '0) tlast_q <= (len_eff == 1);
                STREAM: if (hs) tlast_q <= last_beat ? 1'b0 : ((nxt_idx + 1'b1) == eff_len_q);
                default: tlast_q <= 1'b0;
            endcase
        end
    end
`endif

endmodule

// File: tb/tb_mac_operand_tx.sv
// Directed bench for mac_operand_tx (ADDR_W=4). Checks tlast when
// MAC_OPERAND_TLAST_EN is defined.
module tb_mac_operand_tx;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        wr_en = 1'b0;
    logic        wr_sel = 1'b0;
    logic [3:0]  wr_addr = '0;
    logic [7:0]  wr_data = '0;
    logic [4:0]  len = '0;
    logic        start = 1'b0;
    logic        busy, done, m_axis_tvalid;
    logic        m_axis_tready = 1'b1;
    logic [15:0] m_axis_tdata;
`ifdef MAC_OPERAND_TLAST_EN
    logic        m_axis_tlast;
`endif

    int n_cmp = 0;
    int n_err = 0;

    mac_operand_tx #(.ADDR_W(4)) dut (
        .clk(clk), .reset(reset), .wr_en(wr_en), .wr_sel(wr_sel),
        .wr_addr(wr_addr), .wr_data(wr_data), .len(len), .start(start),
        .busy(busy), .done(done), .m_axis_tvalid(m_axis_tvalid),
        .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata)
`ifdef MAC_OPERAND_TLAST_EN
        , .m_axis_tlast(m_axis_tlast)
`endif
    );

    always #5 clk = ~clk;

    // Advance one edge; inputs are driven and outputs sampled 1 time unit after it
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Streaming beat: tvalid high, busy high, given tdata
    task automatic chk_beat(input string tag, input logic [15:0] exp);
        chk({tag, ".tvalid"}, 16'(m_axis_tvalid), 16'd1);
        chk({tag, ".busy"}, 16'(busy), 16'd1);
        chk({tag, ".tdata"}, m_axis_tdata, exp);
    endtask

    task automatic chk_done(input string tag);
        chk({tag, ".done"}, 16'(done), 16'd1);
        chk({tag, ".tvalid"}, 16'(m_axis_tvalid), 16'd0);
        chk({tag, ".busy"}, 16'(busy), 16'd0);
    endtask

    task automatic wr(input logic sel, input logic [3:0] addr, input logic [7:0] d);
        wr_en = 1'b1; wr_sel = sel; wr_addr = addr; wr_data = d;
        tick();
        wr_en = 1'b0;
    endtask

    task automatic go(input logic [4:0] l);
        len = l; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

`ifdef MAC_OPERAND_TLAST_EN
    task automatic chk_last(input string tag, input logic exp);
        chk(tag, 16'(m_axis_tlast), 16'(exp));
    endtask
`endif

    initial begin
        // Reset state
        tick(); tick();
        chk("rst.tvalid", 16'(m_axis_tvalid), 16'd0);
        chk("rst.busy", 16'(busy), 16'd0);
        chk("rst.done", 16'(done), 16'd0);
        chk("rst.tdata", m_axis_tdata, 16'h0000);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("rst.tlast", 1'b0);
`endif
        reset = 1'b1;
        tick();

        // Basic stream at full throughput
        for (int i = 0; i < 4; i++) begin
            wr(1'b0, 4'(i), 8'(i + 1));
            wr(1'b1, 4'(i), 8'((i + 1) * 16));
        end
        go(5'd4);
        chk_beat("basic.b0", 16'h1001);
        tick(); chk_beat("basic.b1", 16'h2002);
        tick(); chk_beat("basic.b2", 16'h3003);
        tick(); chk_beat("basic.b3", 16'h4004);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("basic.b3.tlast", 1'b1);
`endif
        tick(); chk_done("basic.end");
        tick(); chk("basic.done_clr", 16'(done), 16'd0);

        // Backpressure on beat 1
        go(5'd4);
        chk_beat("bp.b0", 16'h1001);
        tick(); chk_beat("bp.b1", 16'h2002);
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick(); chk_beat("bp.hold", 16'h2002);
        end
        m_axis_tready = 1'b1;
        tick(); chk_beat("bp.b2", 16'h3003);
        tick(); chk_beat("bp.b3", 16'h4004);
        tick(); chk_done("bp.end");
        tick();

        // Zero length
        go(5'd0);
        chk_done("zero.done");
        tick();
        chk("zero.done_clr", 16'(done), 16'd0);
        chk("zero.tvalid2", 16'(m_axis_tvalid), 16'd0);

        // Clamp: len=20 streams all 16 entries
        for (int i = 0; i < 16; i++) begin
            wr(1'b0, 4'(i), 8'(i));
            wr(1'b1, 4'(i), 8'(8'hF0 | 8'(i)));
        end
        go(5'd20);
        for (int i = 0; i < 16; i++) begin
            chk_beat("clamp.beat", {8'(8'hF0 | 8'(i)), 8'(i)});
`ifdef MAC_OPERAND_TLAST_EN
            chk_last("clamp.tlast", i == 15);
`endif
            tick();
        end
        chk_done("clamp.end");
        tick();

        // Reset mid-stream during beat 2
        go(5'd4);
        chk_beat("mid.b0", 16'hF000);
        tick(); chk_beat("mid.b1", 16'hF101);
        tick(); chk_beat("mid.b2", 16'hF202);
        reset = 1'b0;
        tick();
        chk("mid.rst.tvalid", 16'(m_axis_tvalid), 16'd0);
        chk("mid.rst.busy", 16'(busy), 16'd0);
        chk("mid.rst.tdata", m_axis_tdata, 16'h0000);
        reset = 1'b1;
        tick();
        go(5'd1);
        chk_beat("mid.cleared", 16'h0000);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("mid.len1.tlast", 1'b1);
`endif
        tick(); chk_done("mid.end");
        tick();

        // start and wr_en during STREAM are ignored
        for (int i = 0; i < 3; i++) begin
            wr(1'b0, 4'(i), 8'(8'hA1 + i));
            wr(1'b1, 4'(i), 8'(8'hB1 + i));
        end
        go(5'd3);
        chk_beat("ign.b0", 16'hB1A1);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("ign.b0.tlast", 1'b0);
`endif
        start = 1'b1; len = 5'd1;
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h55;
        tick(); chk_beat("ign.b1", 16'hB2A2);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("ign.b1.tlast", 1'b0);
`endif
        tick(); chk_beat("ign.b2", 16'hB3A3);
`ifdef MAC_OPERAND_TLAST_EN
        chk_last("ign.b2.tlast", 1'b1);
`endif
        start = 1'b0; wr_en = 1'b0;
        tick(); chk_done("ign.end");
        tick(); chk("ign.no_restart", 16'(m_axis_tvalid), 16'd0);
        go(5'd1);
        chk_beat("ign.bank_kept", 16'hB1A1);
        tick(); tick();

        // Write and start in the same IDLE cycle: beat 0 sees the old value
        wr_en = 1'b1; wr_sel = 1'b0; wr_addr = 4'd0; wr_data = 8'h77;
        go(5'd1);
        wr_en = 1'b0;
        chk_beat("same.old", 16'hB1A1);
        tick(); tick();
        go(5'd1);
        chk_beat("same.new", 16'hB177);
        tick(); tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
